// File: rtl/frac_lut6_cfg_pkg.sv
// Shared constants and state encoding for the fractured-LUT6 configuration loader.
// Optional feature macro: FRAC_LUT6_CFG_PARITY_EN (adds a trailing XOR parity byte).
package frac_lut6_cfg_pkg;

    localparam int CFG_SRAM_BITS   = 64;
    localparam int CFG_MODE_BITS   = 2;
    localparam int CFG_DATA_BYTES  = 9;
    localparam int CFG_CFG_BITS    = CFG_SRAM_BITS + CFG_MODE_BITS;   // 66 useful bits
    localparam int CFG_SHADOW_BITS = CFG_DATA_BYTES * 8;              // 72 bits incl. reserved
    localparam int CFG_CNT_W       = 4;
    localparam int CFG_TMO_W       = 16;

`ifdef FRAC_LUT6_CFG_PARITY_EN
    localparam int CFG_FRAME_BYTES = 10;
`else
    localparam int CFG_FRAME_BYTES = 9;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/frac_lut6_cfg_shadow.sv
// Byte-addressed 72-bit shadow register for one configuration frame.
// Produces the reserved-bit check and, with FRAC_LUT6_CFG_PARITY_EN, the running
// XOR of data bytes compared against the captured parity byte.
module frac_lut6_cfg_shadow
    import frac_lut6_cfg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [CFG_CNT_W-1:0]     wr_idx,
    input  logic [0:7]               wr_data,
    output logic [0:CFG_CFG_BITS-1]  cfg_bits,
    output logic                     rsvd_err,
    output logic                     parity_err
);

    logic [0:CFG_SHADOW_BITS-1] shadow_d, shadow_q;

    // Next shadow contents: clear on a new frame, else write the addressed byte slot.
    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            shadow_d = '0;
        end else begin
            for (int k = 0; k < CFG_DATA_BYTES; k++) begin
                if (wr_en && (wr_idx == CFG_CNT_W'(k))) begin
                    shadow_d[8*k +: 8] = wr_data;
                end
            end
        end
    end

    // Shadow storage.
    always_ff @(posedge clk) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end

    assign cfg_bits = shadow_q[0:CFG_CFG_BITS-1];
    assign rsvd_err = |shadow_q[CFG_CFG_BITS:CFG_SHADOW_BITS-1];

`ifdef FRAC_LUT6_CFG_PARITY_EN
    logic [0:7] xor_d, xor_q;
    logic [0:7] par_d, par_q;

    // Running XOR over data bytes; the byte after the data bytes is the parity byte.
    always_comb begin
        xor_d = xor_q;
        par_d = par_q;
        if (clr) begin
            xor_d = '0;
            par_d = '0;
        end else if (wr_en) begin
            if (wr_idx < CFG_CNT_W'(CFG_DATA_BYTES)) xor_d = xor_q ^ wr_data;
            else                                     par_d = wr_data;
        end
    end

    // Parity accumulator and captured parity byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= '0;
            par_q <= '0;
        end else begin
            xor_q <= xor_d;
            par_q <= par_d;
        end
    end

    assign parity_err = (xor_q != par_q);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/frac_lut6_cfg_loader.sv
// Configuration loader for one fractured LUT6: collects a byte-serial frame into a
// shadow register, checks it, then commits sram/mode and their complements together.
// Optional feature macro: FRAC_LUT6_CFG_PARITY_EN (10-byte frame with XOR parity).
// Handshake: a byte transfers on a rising edge where cfg_valid and cfg_ready are both 1;
// cfg_ready is high only in LOAD, and cfg_start in LOAD discards that cycle's byte.
module frac_lut6_cfg_loader
    import frac_lut6_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                      prog_clk,
    input  logic                      pReset,
    input  logic                      cfg_start,
    input  logic [0:7]                cfg_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [0:CFG_SRAM_BITS-1]  sram,
    output logic [0:CFG_SRAM_BITS-1]  sram_inv,
    output logic [0:CFG_MODE_BITS-1]  mode,
    output logic [0:CFG_MODE_BITS-1]  mode_inv,
    output logic                      busy,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output cfg_state_t                dbg_state
);

    localparam logic [CFG_TMO_W-1:0] TMO_LIM  = TIMEOUT_CYCLES[CFG_TMO_W-1:0];
    localparam logic [CFG_CNT_W-1:0] LAST_IDX = CFG_CNT_W'(CFG_FRAME_BYTES - 1);

    cfg_state_t                state_d, state_q;
    logic [CFG_CNT_W-1:0]      count_d, count_q;
    logic [CFG_TMO_W-1:0]      tmo_d, tmo_q;
    logic                      err_d, err_q;
    logic                      done_d, done_q;
    logic                      ready_d, ready_q;
    logic                      busy_d, busy_q;
    logic [0:CFG_SRAM_BITS-1]  sram_d, sram_q, sram_inv_d, sram_inv_q;
    logic [0:CFG_MODE_BITS-1]  mode_d, mode_q, mode_inv_d, mode_inv_q;

    logic                      clr, wr_en, hs;
    logic [0:CFG_CFG_BITS-1]   cfg_bits;
    logic                      rsvd_err, parity_err;

    frac_lut6_cfg_shadow u_shadow (
        .clk        (prog_clk),
        .rst        (pReset),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_idx     (count_q),
        .wr_data    (cfg_data),
        .cfg_bits   (cfg_bits),
        .rsvd_err   (rsvd_err),
        .parity_err (parity_err)
    );

    assign hs = cfg_valid & ready_q;

    // Next-state logic for the frame FSM, counters and committed output pair.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        done_d     = 1'b0;
        sram_d     = sram_q;
        sram_inv_d = sram_inv_q;
        mode_d     = mode_q;
        mode_inv_d = mode_inv_q;
        clr        = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    // Restart wins over a byte offered in the same cycle.
                    count_d = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                end else if (hs) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    tmo_d   = '0;
                    if (count_q == LAST_IDX) state_d = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_LIM) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        count_d = '0;
                        tmo_d   = '0;
                        clr     = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (rsvd_err || parity_err) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                sram_d     = cfg_bits[0:CFG_SRAM_BITS-1];
                sram_inv_d = ~cfg_bits[0:CFG_SRAM_BITS-1];
                mode_d     = cfg_bits[CFG_SRAM_BITS:CFG_CFG_BITS-1];
                mode_inv_d = ~cfg_bits[CFG_SRAM_BITS:CFG_CFG_BITS-1];
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    // All loader state and registered outputs; reset is synchronous.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            sram_q     <= '0;
            sram_inv_q <= '1;
            mode_q     <= '0;
            mode_inv_q <= '1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            sram_q     <= sram_d;
            sram_inv_q <= sram_inv_d;
            mode_q     <= mode_d;
            mode_inv_q <= mode_inv_d;
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign sram      = sram_q;
    assign sram_inv  = sram_inv_q;
    assign mode      = mode_q;
    assign mode_inv  = mode_inv_q;
    assign dbg_state = state_q;

endmodule
